iterative_muldiv: RTL and testbench

//   Multi-cycle RV32M multiply/divide unit; successor to the single-cycle ALU, parametrised in datapath width.

---
 rtl/iterative_muldiv.sv | 214 +++++++++++++++++++++
 tb/tb_iterative_muldiv.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/iterative_muldiv.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply and restoring divide at one bit per
// cycle, valid/ready on both sides, tag carried from request to result.
module iterative_muldiv #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};
  localparam logic [WIDTH:0]     ZERO_W1  = {(WIDTH+1){1'b0}};
  localparam logic [CW-1:0]      CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, quo_q, quo_d, res_q, res_d;
  logic [TAG_W-1:0]   tag_q, tag_d, otag_q, otag_d;
  logic               neg_q, neg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;

  logic               accept_s, special_s;
  logic [WIDTH-1:0]   special_res_s;
  logic               sign_a_s, sign_b_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s, quo_fix_s, rem_fix_s;
  logic [WIDTH:0]     sum_s, shifted_s, diff_s;
  logic [2*WIDTH-1:0] prod_fix_s;

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      a_q     <= ZERO_W;
      b_q     <= ZERO_W;
      quo_q   <= ZERO_W;
      res_q   <= ZERO_W;
      tag_q   <= {TAG_W{1'b0}};
      otag_q  <= {TAG_W{1'b0}};
      neg_q   <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      acc_q   <= ZERO_2W;
      rem_q   <= ZERO_W1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      otag_q  <= otag_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  // Request decode and arithmetic step values shared by the FSM and datapath
  always_comb begin
    accept_s  = (state_q == S_IDLE) && in_valid && !flush;
    special_s = 1'b0;
    special_res_s = ZERO_W;
    if (in_op[2] && (in_b == ZERO_W)) begin
      special_s     = 1'b1;
      special_res_s = in_op[1] ? in_a : ONES_W;
    end else if (in_op[2] && !in_op[0] && (in_a == MIN_INT) && (in_b == ONES_W)) begin
      special_s     = 1'b1;
      special_res_s = in_op[1] ? ZERO_W : MIN_INT;
    end else begin
      special_s     = 1'b0;
    end
    // a is signed for MULH/MULHSU/DIV/REM, b only for MULH/DIV/REM
    sign_a_s   = a_q[WIDTH-1] && ((op_q == 3'b001) || (op_q == 3'b010) ||
                                  (op_q == 3'b100) || (op_q == 3'b110));
    sign_b_s   = b_q[WIDTH-1] && ((op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110));
    abs_a_s    = sign_a_s ? (ZERO_W - a_q) : a_q;
    abs_b_s    = sign_b_s ? (ZERO_W - b_q) : b_q;
    sum_s      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : ZERO_W1);
    shifted_s  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff_s     = shifted_s - {1'b0, b_q};
    prod_fix_s = neg_q ? (ZERO_2W - acc_q) : acc_q;
    quo_fix_s  = neg_q ? (ZERO_W - quo_q) : quo_q;
    rem_fix_s  = neg_q ? (ZERO_W - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
  end

  // Next-state logic; flush forces IDLE from any state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = special_s ? S_DONE : S_PREP;
        else          state_d = S_IDLE;
      end
      S_PREP: state_d = S_CALC;
      S_CALC: begin
        if (cnt_q == CNT_ONE) state_d = S_FIX;
        else                  state_d = S_CALC;
      end
      S_FIX:  state_d = S_DONE;
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
        else           state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
    else       state_d = state_d;
  end

  // Datapath register updates per state
  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    quo_d  = quo_q;
    res_d  = res_q;
    tag_d  = tag_q;
    otag_d = otag_q;
    neg_d  = neg_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    rem_d  = rem_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d  = in_op;
          a_d   = in_a;
          b_d   = in_b;
          tag_d = in_tag;
          if (special_s) begin
            res_d  = special_res_s;
            otag_d = in_tag;
          end else begin
            res_d  = res_q;
          end
        end else begin
          op_d = op_q;
        end
      end
      S_PREP: begin
        neg_d = (op_q[2] && op_q[1]) ? sign_a_s : (sign_a_s ^ sign_b_s);
        b_d   = abs_b_s;
        cnt_d = CNT_INIT;
        acc_d = {ZERO_W, abs_a_s};
        quo_d = abs_a_s;
        rem_d = ZERO_W1;
      end
      S_CALC: begin
        cnt_d = cnt_q - CNT_ONE;
        if (op_q[2]) begin
          // Restoring step: keep the trial subtraction only when it does not go negative
          if (!diff_s[WIDTH]) begin
            rem_d = diff_s;
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted_s;
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {sum_s, acc_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        otag_d = tag_q;
        case (op_q)
          3'b000:                 res_d = prod_fix_s[WIDTH-1:0];
          3'b001, 3'b010, 3'b011: res_d = prod_fix_s[2*WIDTH-1:WIDTH];
          3'b100, 3'b101:         res_d = quo_fix_s;
          default:                res_d = rem_fix_s;
        endcase
      end
      default: begin
        res_d = res_q;
      end
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready   = (state_q == S_IDLE);
    out_valid  = (state_q == S_DONE);
    out_result = res_q;
    out_tag    = otag_q;
  end

endmodule

// File: tb/tb_iterative_muldiv.sv
// Scoreboard bench for iterative_muldiv (WIDTH=32): directed vectors push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_iterative_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, flush;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;

  int n_vec  = 0;
  int n_miss = 0;
  logic [36:0] sb_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;
  vec_t vecs[16];

  iterative_muldiv #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted result must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", {27'd0, out_tag, out_result}, 64'd0);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        chk("result", {32'd0, out_result}, {32'd0, e[31:0]});
        chk("tag", {59'd0, out_tag}, {59'd0, e[36:32]});
      end
    end
  end

  // Present one request; returns at accept edge + 1
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_tag = 5'($urandom);
  endtask

  task automatic wait_valid(input bit special);
    int edges;
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    // special cases are valid in the cycle right after accept, others after 34 edges
    chk("latency_edges", 64'(edges), special ? 64'd0 : 64'd34);
  endtask

  task automatic run(input int idx, input logic [4:0] tag);
    sb_q.push_back({tag, vecs[idx].exp});
    send(vecs[idx].op, vecs[idx].a, vecs[idx].b, tag);
    wait_valid(vecs[idx].special);
    @(posedge clk); #1;
  endtask

  task automatic watch_quiet(input string name);
    bit seen;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       1'b0};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        1'b0};
    vecs[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        1'b1};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[12] = '{3'b001, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFF, 1'b0};
    vecs[13] = '{3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[14] = '{3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[15] = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    in_op = 3'd0; in_a = 32'd0; in_b = 32'd0; in_tag = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out", {27'd0, out_tag, out_result}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run(i, 5'(i + 1));

    // Back-pressure: result and tag must hold while out_ready is low
    out_ready = 1'b0;
    sb_q.push_back({5'd20, 32'd42});
    send(3'b000, 32'd6, 32'd7, 5'd20);
    wait_valid(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold", {26'd0, out_valid, in_ready, out_tag, out_result}, {26'd0, 1'b1, 1'b0, 5'd20, 32'd42});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_hs", 64'(in_ready), 64'd1);

    // Flush during CALC, then flush beating a simultaneous request in IDLE
    send(3'b000, 32'd9, 32'd9, 5'd21);
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
    in_op = 3'b101; in_a = 32'd8; in_b = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_beats_valid", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
    watch_quiet("flush_no_output");

    // Reset in the middle of CALC discards the operation and clears the outputs
    send(3'b101, 32'd1000, 32'd3, 5'd22);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_idle", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
    chk("rst_out", {27'd0, out_tag, out_result}, 64'd0);
    watch_quiet("rst_no_output");

    sb_q.push_back({5'd23, 32'd12});
    send(3'b000, 32'd3, 32'd4, 5'd23);
    wait_valid(1'b0);
    @(posedge clk); #1;

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
